multiplier_sequencer: RTL and testbench

//  Upstream control stage for the registered multiplier (operand regs A/B, product reg).

---
 rtl/multiplier_sequencer.sv | 147 ++++++++++++++
 tb/tb_multiplier_sequencer.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/multiplier_sequencer.sv
// Sequencer for a registered multiplier: takes operand pairs on a valid/ready stream, strobes the
// multiplier registers, and returns the signed product on a valid/ready stream. Define MULT_ERR_CHECK_EN to abort ops on register access errors.
module multiplier_sequencer #(
  parameter int N     = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inValid,
  output logic             inReady,
  input  logic [N-1:0]     inA,
  input  logic [N-1:0]     inB,
  output logic [N-1:0]     mulA,
  output logic [N-1:0]     mulB,
  output logic             mulWeA,
  output logic             mulWeB,
  output logic             mulReA,
  output logic             mulReB,
  output logic             mulWeOut,
  output logic             mulReOut,
  output logic             mulRstA,
  output logic             mulRstB,
  output logic             mulRstOut,
  input  logic [2*N-1:0]   mulProduct,
  input  logic             mulErrA,
  input  logic             mulErrB,
  input  logic             mulErrOut,
  output logic             outValid,
  input  logic             outReady,
  output logic [2*N-1:0]   outProduct,
  output logic             outError,
  output logic [CNT_W-1:0] opCount
);

  typedef enum logic [2:0] {IDLE, LOAD, MUL, READ, CAPT, OUT} state_t;

  state_t       state, stateNext;
  logic [N-1:0] opA, opB;
  logic         err;
  logic         busy;

`ifdef MULT_ERR_CHECK_EN
  assign err = mulErrA | mulErrB | mulErrOut;
`else
  logic unusedErr;
  assign unusedErr = mulErrA ^ mulErrB ^ mulErrOut;
  assign err       = 1'b0;
`endif

  assign mulRstA   = reset;
  assign mulRstB   = reset;
  assign mulRstOut = reset;
  assign mulA      = opA;
  assign mulB      = opB;
  assign busy      = (state == LOAD) || (state == MUL) || (state == READ) || (state == CAPT);

  always_comb begin
    stateNext = state;
    inReady   = 1'b0;
    outValid  = 1'b0;
    mulWeA    = 1'b0;
    mulWeB    = 1'b0;
    mulReA    = 1'b0;
    mulReB    = 1'b0;
    mulWeOut  = 1'b0;
    mulReOut  = 1'b0;
    case (state)
      IDLE: begin
        inReady = 1'b1;
        if (inValid) stateNext = LOAD;
      end
      LOAD: begin
        mulWeA    = 1'b1;
        mulWeB    = 1'b1;
        stateNext = MUL;
      end
      MUL: begin
        mulReA    = 1'b1;
        mulReB    = 1'b1;
        mulWeOut  = 1'b1;
        stateNext = READ;
      end
      READ: begin
        mulReA    = 1'b1;
        mulReB    = 1'b1;
        mulReOut  = 1'b1;
        stateNext = CAPT;
      end
      CAPT: begin
        mulReOut  = 1'b1;
        stateNext = OUT;
      end
      OUT: begin
        outValid = 1'b1;
        if (outReady) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
    // An access error kills every strobe on the abort edge and jumps straight to OUT
    if (busy && err) begin
      stateNext = OUT;
      mulWeA    = 1'b0;
      mulWeB    = 1'b0;
      mulReA    = 1'b0;
      mulReB    = 1'b0;
      mulWeOut  = 1'b0;
      mulReOut  = 1'b0;
    end
    // Nothing handshakes or strobes while reset is held
    if (reset) begin
      inReady  = 1'b0;
      outValid = 1'b0;
      mulWeA   = 1'b0;
      mulWeB   = 1'b0;
      mulReA   = 1'b0;
      mulReB   = 1'b0;
      mulWeOut = 1'b0;
      mulReOut = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      opA        <= '0;
      opB        <= '0;
      outProduct <= '0;
      outError   <= 1'b0;
      opCount    <= '0;
    end else begin
      state <= stateNext;
      if (state == IDLE && inValid) begin
        opA <= inA;
        opB <= inB;
      end
      if (busy && err) begin
        outProduct <= '0;
        outError   <= 1'b1;
      end else if (state == CAPT) begin
        outProduct <= mulProduct;
        outError   <= 1'b0;
      end
      if (state == OUT && outReady) opCount <= opCount + 1'b1;
    end
  end

endmodule

// File: tb/tb_multiplier_sequencer.sv
// Bench for multiplier_sequencer: behavioural registered-multiplier model plus directed and random ops
// checked against products computed with plain 64-bit arithmetic.
module tb_multiplier_sequencer;
  localparam int N  = 32;
  localparam int CW = 4;
`ifdef MULT_ERR_CHECK_EN
  localparam bit ERRCHK = 1'b1;
`else
  localparam bit ERRCHK = 1'b0;
`endif

  logic clk = 1'b0, reset = 1'b1;
  logic inValid = 1'b0, inReady, outValid, outReady = 1'b0, outError;
  logic [N-1:0] inA = '0, inB = '0, mulA, mulB;
  logic mulWeA, mulWeB, mulReA, mulReB, mulWeOut, mulReOut, mulRstA, mulRstB, mulRstOut;
  logic mulErrA = 1'b0, mulErrB = 1'b0, mulErrOut = 1'b0;
  logic [2*N-1:0] mulProduct, outProduct;
  logic [CW-1:0] opCount;

  int checks = 0, errors = 0;
  logic [CW-1:0] expCount = '0;

  always #5 clk = ~clk;

  multiplier_sequencer #(.N(N), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .inValid(inValid), .inReady(inReady), .inA(inA), .inB(inB),
    .mulA(mulA), .mulB(mulB), .mulWeA(mulWeA), .mulWeB(mulWeB), .mulReA(mulReA), .mulReB(mulReB),
    .mulWeOut(mulWeOut), .mulReOut(mulReOut), .mulRstA(mulRstA), .mulRstB(mulRstB),
    .mulRstOut(mulRstOut), .mulProduct(mulProduct), .mulErrA(mulErrA), .mulErrB(mulErrB),
    .mulErrOut(mulErrOut), .outValid(outValid), .outReady(outReady), .outProduct(outProduct),
    .outError(outError), .opCount(opCount)
  );

  // Registered multiplier: operand regs, product reg computed only when both operands are read
  logic signed [N-1:0]   rA, rB;
  logic signed [2*N-1:0] rP;
  always_ff @(posedge clk) begin
    if (mulRstA) rA <= '0; else if (mulWeA) rA <= mulA;
    if (mulRstB) rB <= '0; else if (mulWeB) rB <= mulB;
    if (mulRstOut) rP <= '0; else if (mulWeOut && mulReA && mulReB) rP <= rA * rB;
  end
  assign mulProduct = rP;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] expStrobe(input int k);
    case (k)
      1: return 6'b110000;
      2: return 6'b001110;
      3: return 6'b001101;
      4: return 6'b000001;
      default: return 6'b000000;
    endcase
  endfunction

  function automatic logic [5:0] strobes();
    return {mulWeA, mulWeB, mulReA, mulReB, mulWeOut, mulReOut};
  endfunction

  task automatic doOp(input logic [N-1:0] a, input logic [N-1:0] b, input int stall, input bit errB);
    logic [63:0] expP;
    bit ab;
    int nk;
    ab   = errB && ERRCHK;
    nk   = ab ? 2 : 4;
    expP = ab ? 64'd0 : 64'(longint'($signed(a)) * longint'($signed(b)));
    @(negedge clk);
    chk("idleReady", 64'(inReady), 64'd1);
    inA = a; inB = b; inValid = 1'b1;
    @(posedge clk); #1;
    inValid = 1'b0; inA = $urandom; inB = $urandom;
    for (int k = 1; k <= nk; k++) begin
      if (errB && k == 2) mulErrB = 1'b1;
      @(negedge clk);
      chk($sformatf("strobe%0d", k), 64'(strobes()), 64'((ab && k == 2) ? 6'b0 : expStrobe(k)));
      chk("busyNotReady", 64'({inReady, outValid}), 64'd0);
      @(posedge clk); #1;
      mulErrB = 1'b0;
    end
    for (int s = 0; s < stall; s++) begin
      inValid = 1'b1; inA = $urandom; inB = $urandom;
      @(negedge clk);
      chk("stallValid", 64'({outValid, inReady}), 64'b10);
      chk("stallProduct", outProduct, expP);
      chk("stallError", 64'(outError), 64'(ab));
      @(posedge clk); #1;
    end
    inValid = 1'b1; outReady = 1'b1;
    @(negedge clk);
    chk("outValid", 64'({outValid, inReady}), 64'b10);
    chk("outProduct", outProduct, expP);
    chk("outError", 64'(outError), 64'(ab));
    chk("countBefore", 64'(opCount), 64'(expCount));
    @(posedge clk); #1;
    outReady = 1'b0; inValid = 1'b0;
    expCount = expCount + 1'b1;
    @(negedge clk);
    chk("countAfter", 64'(opCount), 64'(expCount));
    chk("backIdle", 64'({inReady, outValid}), 64'b10);
  endtask

  initial begin
    // Reset held three cycles
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rstReady", 64'({inReady, outValid}), 64'd0);
      chk("rstCount", 64'(opCount), 64'd0);
      chk("rstPass", 64'({mulRstA, mulRstB, mulRstOut}), 64'b111);
      chk("rstStrobes", 64'(strobes()), 64'd0);
      @(posedge clk); #1;
    end
    reset = 1'b0;
    @(negedge clk);
    chk("relReady", 64'(inReady), 64'd1);
    chk("relProduct", outProduct, 64'd0);
    chk("relRst", 64'({mulRstA, mulRstB, mulRstOut}), 64'd0);

    doOp(32'd7, -32'sd3, 0, 1'b0);
    chk("minus21", outProduct, 64'hFFFF_FFFF_FFFF_FFEB);
    doOp(32'h8000_0000, 32'h8000_0000, 1, 1'b0);
    chk("minSq", outProduct, 64'h4000_0000_0000_0000);
    doOp(32'h7FFF_FFFF, 32'h8000_0000, 6, 1'b0);

    // Reset in MUL abandons the op and clears the count
    @(negedge clk);
    inA = 32'd5; inB = 32'd9; inValid = 1'b1;
    @(posedge clk); #1; inValid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("midRstStrobes", 64'(strobes()), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    expCount = '0;
    @(negedge clk);
    chk("midRstIdle", 64'({inReady, outValid}), 64'b10);
    chk("midRstCount", 64'(opCount), 64'd0);
    chk("midRstProduct", outProduct, 64'd0);

    doOp(32'd123456, -32'sd789, 2, 1'b1);
    doOp(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
    doOp(32'd0, 32'h1234_5678, 1, 1'b0);

    // Random ops; enough of them to wrap the narrow counter
    for (int i = 0; i < 20; i++)
      doOp($urandom, $urandom, $urandom_range(0, 3), ($urandom_range(0, 3) == 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
